// File: rtl/fpu_issue_scheduler_pkg.sv
// Shared types for the FPU issue scheduler.
// Operation codes and scheduler FSM states.
package fpu_op;

  typedef enum logic [2:0] {
    ADD,
    SUB,
    MUL,
    DIV,
    SQRT,
    CONVERT
  } op_type;

  function automatic logic is_iterative(op_type op);
    return (op == DIV) || (op == SQRT);
  endfunction

endpackage

package fpu_issue;

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    FINISH
  } sched_state;

endpackage

// File: rtl/fpu_issue_scheduler_tag_pipe.sv
// Valid+tag shift register tracking ops in the FPU pipeline.
// Single load port feeds stage 0; the last stage is the result.
module fpu_issue_tag_pipe #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [TAG_WIDTH-1:0] load_tag,
  output logic [DEPTH-1:0]     valid,
  output logic [TAG_WIDTH-1:0] tag_out
);

  logic [TAG_WIDTH-1:0] tags [DEPTH];

  // Advance every stage each cycle; results are never held.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
    end else begin
      valid   <= {valid[DEPTH-2:0], load};
      tags[0] <= load ? load_tag : '0;
      for (int i = 1; i < DEPTH; i++) tags[i] <= tags[i-1];
    end
  end

  assign tag_out = tags[DEPTH-1];

endmodule

// File: rtl/fpu_issue_scheduler.sv
// Issue controller at the front of the pipelined FPU.
// Optional macro FPU_ISSUE_PERF_COUNTERS_EN adds perf counters.
module fpu_issue_scheduler
  import fpu_op::*;
  import fpu_issue::*;
#(
  parameter int PIPE_LATENCY = 4,
  parameter int DIV_ITERS    = 26,
  parameter int SQRT_ITERS   = 25,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  op_type                  req_op,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic [PIPE_LATENCY-1:0] pipe_valid,
  output logic                    iter_load,
  output logic                    iter_enable,
  output logic                    iter_last,
  output logic                    iter_is_sqrt,
  output logic                    result_valid,
  output logic [TAG_WIDTH-1:0]    result_tag,
  output logic                    busy
`ifdef FPU_ISSUE_PERF_COUNTERS_EN
  ,
  output logic [31:0]             perf_issued,
  output logic [31:0]             perf_stall,
  output logic [31:0]             perf_iter
`endif
);

  localparam int MAX_ITERS =
    (DIV_ITERS > SQRT_ITERS) ? DIV_ITERS : SQRT_ITERS;
  localparam int CW = $clog2(MAX_ITERS);

  if (PIPE_LATENCY < 2) begin : g_bad_lat
    $error("PIPE_LATENCY must be at least 2");
  end
  if (DIV_ITERS <= PIPE_LATENCY) begin : g_bad_div
    $error("DIV_ITERS must exceed PIPE_LATENCY");
  end
  if (SQRT_ITERS <= PIPE_LATENCY) begin : g_bad_sqrt
    $error("SQRT_ITERS must exceed PIPE_LATENCY");
  end

  sched_state           state;
  sched_state           next_state;
  logic [CW-1:0]        cnt;
  logic [TAG_WIDTH-1:0] iter_tag;
  logic                 accept;
  logic                 is_iter;
  logic                 pipe_load;
  logic [TAG_WIDTH-1:0] pipe_tag;

  assign is_iter = is_iterative(req_op);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: iterative ops divert through ITERATE/FINISH.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept && is_iter) next_state = ITERATE;
      ITERATE: if (cnt == '0) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: handshake, iteration strobes, pipe injection.
  always_comb begin
    req_ready   = (state == IDLE) && !reset;
    accept      = req_valid && req_ready;
    iter_enable = (state == ITERATE);
    iter_last   = (state == ITERATE) && (cnt == '0);
    pipe_load   = (accept && !is_iter) || (state == FINISH);
    pipe_tag    = (state == FINISH) ? iter_tag : req_tag;
    busy        = (state != IDLE) || (|pipe_valid);
  end

  // Iteration bookkeeping: counter, saved tag, sqrt select, load pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      iter_tag     <= '0;
      iter_is_sqrt <= 1'b0;
      iter_load    <= 1'b0;
    end else begin
      iter_load <= accept && is_iter;
      if (accept && is_iter) begin
        cnt          <= (req_op == SQRT) ? CW'(SQRT_ITERS - 1)
                                         : CW'(DIV_ITERS - 1);
        iter_is_sqrt <= (req_op == SQRT);
        iter_tag     <= req_tag;
      end else if (state == ITERATE && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  fpu_issue_tag_pipe #(
    .DEPTH    (PIPE_LATENCY),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .load    (pipe_load),
    .load_tag(pipe_tag),
    .valid   (pipe_valid),
    .tag_out (result_tag)
  );

  assign result_valid = pipe_valid[PIPE_LATENCY-1];

`ifdef FPU_ISSUE_PERF_COUNTERS_EN
  // Saturating event counters for issue, stall and iteration cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_iter   <= '0;
    end else begin
      if (accept && perf_issued != '1)
        perf_issued <= perf_issued + 32'd1;
      if (req_valid && !req_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
      if (state == ITERATE && perf_iter != '1)
        perf_iter <= perf_iter + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Directed self-checking bench for fpu_issue_scheduler.
// Inputs driven and outputs sampled on the falling edge.
module tb_fpu_issue_scheduler;
  import fpu_op::*;

  localparam int PL = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  op_type        req_op = ADD;
  logic [TW-1:0] req_tag = '0;
  logic [PL-1:0] pipe_valid;
  logic          iter_load;
  logic          iter_enable;
  logic          iter_last;
  logic          iter_is_sqrt;
  logic          result_valid;
  logic [TW-1:0] result_tag;
  logic          busy;
`ifdef FPU_ISSUE_PERF_COUNTERS_EN
  logic [31:0]   perf_issued;
  logic [31:0]   perf_stall;
  logic [31:0]   perf_iter;
`endif

  int tests = 0;
  int fails = 0;
  logic seen;

  fpu_issue_scheduler #(
    .PIPE_LATENCY(PL),
    .DIV_ITERS   (26),
    .SQRT_ITERS  (25),
    .TAG_WIDTH   (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_tag     (req_tag),
    .pipe_valid  (pipe_valid),
    .iter_load   (iter_load),
    .iter_enable (iter_enable),
    .iter_last   (iter_last),
    .iter_is_sqrt(iter_is_sqrt),
    .result_valid(result_valid),
    .result_tag  (result_tag),
    .busy        (busy)
`ifdef FPU_ISSUE_PERF_COUNTERS_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
    .perf_iter   (perf_iter)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick;
    tick;
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_pipe", 32'(pipe_valid), 32'(0));
    check("rst_rv", 32'(result_valid), 32'(0));
    check("rst_rtag", 32'(result_tag), 32'(0));
    check("rst_load", 32'(iter_load), 32'(0));
    check("rst_en", 32'(iter_enable), 32'(0));
    check("rst_last", 32'(iter_last), 32'(0));
    check("rst_sqrt", 32'(iter_is_sqrt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'(1));

    // Single ADD tag 3, walk the pipe
    req_valid = 1'b1; req_op = ADD; req_tag = 4'd3;
    tick;
    req_valid = 1'b0;
    check("t1_pv1", 32'(pipe_valid), 32'h1);
    tick;
    check("t1_pv2", 32'(pipe_valid), 32'h2);
    tick;
    check("t1_pv3", 32'(pipe_valid), 32'h4);
    check("t1_rv3", 32'(result_valid), 32'(0));
    tick;
    check("t1_pv4", 32'(pipe_valid), 32'h8);
    check("t1_rv4", 32'(result_valid), 32'(1));
    check("t1_tag4", 32'(result_tag), 32'(3));
    tick;
    check("t1_rv5", 32'(result_valid), 32'(0));
    check("t1_busy5", 32'(busy), 32'(0));

    // Back-to-back ADD tags 0..7
    for (int k = 0; k <= 12; k++) begin
      req_valid = (k < 8); req_op = ADD; req_tag = TW'(k);
      #1;
      if (k < 8) check("t2_ready", 32'(req_ready), 32'(1));
      check("t2_rv", 32'(result_valid), 32'(k >= 4 && k <= 11));
      if (k >= 4 && k <= 11)
        check("t2_tag", 32'(result_tag), 32'(k - 4));
      tick;
    end

    // DIV tag 5, then MUL tag 6 held until accepted
    for (int k = 0; k <= 33; k++) begin
      req_valid = (k <= 28);
      req_op    = (k == 0) ? DIV : MUL;
      req_tag   = (k == 0) ? 4'd5 : 4'd6;
      #1;
      check("t3_load", 32'(iter_load), 32'(k == 1));
      check("t3_en", 32'(iter_enable), 32'(k >= 1 && k <= 26));
      check("t3_last", 32'(iter_last), 32'(k == 26));
      check("t3_ready", 32'(req_ready), 32'(k == 0 || k >= 28));
      check("t3_rv", 32'(result_valid), 32'(k == 31 || k == 32));
      if (k == 5) check("t3_sqrt", 32'(iter_is_sqrt), 32'(0));
      if (k == 20) check("t3_busy", 32'(busy), 32'(1));
      if (k == 31) check("t3_tag31", 32'(result_tag), 32'(5));
      if (k == 32) check("t3_tag32", 32'(result_tag), 32'(6));
      tick;
    end

    // ADD tag 1 then SQRT tag 2
    for (int k = 0; k <= 33; k++) begin
      req_valid = (k <= 1);
      req_op    = (k == 0) ? ADD : SQRT;
      req_tag   = (k == 0) ? 4'd1 : 4'd2;
      #1;
      check("t4_rv", 32'(result_valid), 32'(k == 4 || k == 31));
      check("t4_last", 32'(iter_last), 32'(k == 26));
      if (k == 10) check("t4_sqrt", 32'(iter_is_sqrt), 32'(1));
      if (k == 4) check("t4_tag4", 32'(result_tag), 32'(1));
      if (k == 31) check("t4_tag31", 32'(result_tag), 32'(2));
      tick;
    end

    // Reset while iterating (counter at 10)
    seen = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      req_valid = (k == 0); req_op = DIV; req_tag = 4'd9;
      if (k == 16) reset = 1'b1;
      #1;
      if (k == 16) check("t5_en_pre", 32'(iter_enable), 32'(1));
      tick;
    end
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    check("t5_ready", 32'(req_ready), 32'(1));
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_en", 32'(iter_enable), 32'(0));
    check("t5_pipe", 32'(pipe_valid), 32'(0));
    for (int k = 0; k < 40; k++) begin
      seen = seen | result_valid;
      tick;
    end
    check("t5_no_result", 32'(seen), 32'(0));

    // Out-of-enum op behaves as single-pass
    req_valid = 1'b1; req_op = op_type'(3'd7); req_tag = 4'd7;
    tick;
    req_valid = 1'b0; req_op = ADD;
    check("t6_load", 32'(iter_load), 32'(0));
    check("t6_pv", 32'(pipe_valid), 32'h1);
    tick;
    tick;
    tick;
    check("t6_rv", 32'(result_valid), 32'(1));
    check("t6_tag", 32'(result_tag), 32'(7));
    tick;

`ifdef FPU_ISSUE_PERF_COUNTERS_EN
    // Perf counters: one DIV plus a waiting ADD
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    check("p_issued0", perf_issued, 32'(0));
    check("p_stall0", perf_stall, 32'(0));
    check("p_iter0", perf_iter, 32'(0));
    for (int k = 0; k <= 33; k++) begin
      req_valid = (k <= 28);
      req_op    = (k == 0) ? DIV : ADD;
      req_tag   = 4'd1;
      tick;
    end
    check("p_issued", perf_issued, 32'(2));
    check("p_iter", perf_iter, 32'(26));
    check("p_stall", perf_stall, 32'(27));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
